bist_controller: RTL and testbench

Sequencing FSM for the on-chip logic BIST of the `chip` top level. It sits between the `bistmode`/`bistdone`/`bistpass` pins and the BIST datapath: the PI-side LFSR pattern generator, the scan chain through the CUT flip-flops, and the PO-side MISR. Each run reseeds the LFSR and clears the MISR, then applies a fixed number of scan patterns (shift, then capture). It unloads the last response, compares the MISR signature against a hard-wired golden value and reports the result.

---
 rtl/bist_pkg.sv | 18 +
 rtl/bist_cnt.sv | 27 ++
 rtl/bist_controller.sv | 165 ++++++++++++++++
 tb/tb_bist_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the logic-BIST sequencer and its LFSR/MISR neighbours.
package bist_pkg;

  localparam int SCAN_LEN_DEF     = 179;
  localparam int NUM_PATTERNS_DEF = 1024;
  localparam int SIG_W_DEF        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } bist_state_t;

endpackage

// File: rtl/bist_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count
// flag raised while the count sits at LIMIT-1.
module bist_cnt #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/bist_controller.sv
// Logic-BIST sequencer: seeds the LFSR, clears the MISR, runs NUM_PATTERNS
// shift/capture patterns, unloads, then checks the MISR against GOLDEN_SIG.
module bist_controller
  import bist_pkg::*;
#(
  parameter int                NUM_PATTERNS = NUM_PATTERNS_DEF,
  parameter int                SCAN_LEN     = SCAN_LEN_DEF,
  parameter int                SIG_W        = SIG_W_DEF,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG   = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                bistmode,
  input  logic [SIG_W-1:0]                    misr_sig,
  output logic                                test_mode,
  output logic                                lfsr_seed,
  output logic                                lfsr_en,
  output logic                                misr_clr,
  output logic                                misr_en,
  output logic                                scan_en,
  output logic                                bistdone,
  output logic                                bistpass,
  output bist_state_t                         state_dbg,
  output logic [$clog2(SCAN_LEN+1)-1:0]       shift_cnt_dbg,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]   pat_cnt_dbg
);

  localparam int SHIFT_W = $clog2(SCAN_LEN + 1);
  localparam int PAT_W   = $clog2(NUM_PATTERNS + 1);

  // bistmode is a level request with no handshake: 1 starts or holds a run,
  // 0 aborts any run on the next edge. Outputs decode only registered state.
  bist_state_t        state_q, state_d;
  logic               pass_q;
  logic               shift_clr, shift_en, shift_tc;
  logic               pat_clr, pat_en, pat_tc;
  logic [SHIFT_W-1:0] shift_cnt;
  logic [PAT_W-1:0]   pat_cnt;
  logic               abort;

  assign abort = (state_q != ST_IDLE) && !bistmode;

  bist_cnt #(.LIMIT(SCAN_LEN), .W(SHIFT_W)) u_shift_cnt (
    .clk (clk),
    .rst (rst),
    .clr (shift_clr),
    .en  (shift_en),
    .cnt (shift_cnt),
    .tc  (shift_tc)
  );

  bist_cnt #(.LIMIT(NUM_PATTERNS), .W(PAT_W)) u_pat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (pat_clr),
    .en  (pat_en),
    .cnt (pat_cnt),
    .tc  (pat_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_q <= 1'b0;
    end else if (abort || state_q == ST_IDLE || state_q == ST_INIT) begin
      pass_q <= 1'b0;
    end else if (state_q == ST_COMPARE) begin
      pass_q <= (misr_sig == GOLDEN_SIG);
    end
  end

  always_comb begin
    state_d   = state_q;
    test_mode = 1'b0;
    lfsr_seed = 1'b0;
    lfsr_en   = 1'b0;
    misr_clr  = 1'b0;
    misr_en   = 1'b0;
    scan_en   = 1'b0;
    bistdone  = 1'b0;
    bistpass  = 1'b0;
    shift_clr = 1'b0;
    shift_en  = 1'b0;
    pat_clr   = 1'b0;
    pat_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        shift_clr = 1'b1;
        pat_clr   = 1'b1;
        if (bistmode) state_d = ST_INIT;
      end
      ST_INIT: begin
        test_mode = 1'b1;
        lfsr_seed = 1'b1;
        misr_clr  = 1'b1;
        shift_clr = 1'b1;
        pat_clr   = 1'b1;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        test_mode = 1'b1;
        scan_en   = 1'b1;
        lfsr_en   = 1'b1;
        // The first load unloads reset state, which must not reach the MISR.
        misr_en   = (pat_cnt != '0);
        if (shift_tc) begin
          shift_clr = 1'b1;
          state_d   = ST_CAPTURE;
        end else begin
          shift_en  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        test_mode = 1'b1;
        lfsr_en   = 1'b1;
        misr_en   = 1'b1;
        pat_en    = 1'b1;
        state_d   = pat_tc ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        test_mode = 1'b1;
        scan_en   = 1'b1;
        lfsr_en   = 1'b1;
        misr_en   = 1'b1;
        if (shift_tc) begin
          shift_clr = 1'b1;
          state_d   = ST_COMPARE;
        end else begin
          shift_en  = 1'b1;
        end
      end
      ST_COMPARE: begin
        test_mode = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        test_mode = 1'b1;
        bistdone  = 1'b1;
        bistpass  = pass_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      shift_clr = 1'b1;
      pat_clr   = 1'b1;
      shift_en  = 1'b0;
      pat_en    = 1'b0;
    end
  end

  assign state_dbg     = state_q;
  assign shift_cnt_dbg = shift_cnt;
  assign pat_cnt_dbg   = pat_cnt;

endmodule

// File: tb/tb_bist_controller.sv
// Randomized bench for bist_controller: a cycle-indexed phase model of a run
// predicts every output; aborts and async resets are injected at random points.
module tb_bist_controller;
  import bist_pkg::*;

  localparam int          SL      = 4;
  localparam int          NP      = 3;
  localparam logic [15:0] GOLDEN  = 16'hBEEF;
  localparam int          PAT_CYC = NP * (SL + 1);
  localparam int          CMP_K   = PAT_CYC + SL + 1;
  localparam int          DONE_K  = CMP_K + 1;
  localparam int          K_FULL  = 0;
  localparam int          K_ABORT = 1;
  localparam int          K_RESET = 2;

  logic        clk;
  logic        rst;
  logic        bistmode;
  logic [15:0] misr_sig;
  logic        test_mode, lfsr_seed, lfsr_en, misr_clr, misr_en, scan_en;
  logic        bistdone, bistpass;
  bist_state_t state_dbg;
  logic [2:0]  shift_cnt_dbg;
  logic [1:0]  pat_cnt_dbg;

  int errors = 0;
  int checks = 0;

  bist_controller #(
    .NUM_PATTERNS (NP),
    .SCAN_LEN     (SL),
    .SIG_W        (16),
    .GOLDEN_SIG   (GOLDEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bistmode      (bistmode),
    .misr_sig      (misr_sig),
    .test_mode     (test_mode),
    .lfsr_seed     (lfsr_seed),
    .lfsr_en       (lfsr_en),
    .misr_clr      (misr_clr),
    .misr_en       (misr_en),
    .scan_en       (scan_en),
    .bistdone      (bistdone),
    .bistpass      (bistpass),
    .state_dbg     (state_dbg),
    .shift_cnt_dbg (shift_cnt_dbg),
    .pat_cnt_dbg   (pat_cnt_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {test_mode, lfsr_seed, lfsr_en, misr_clr, misr_en, scan_en, bistdone, bistpass};
  endfunction

  // Reference: phase of cycle k counted from INIT entry (k=0).
  function automatic bist_state_t exp_state(input int k);
    if (k == 0) return ST_INIT;
    if (k <= PAT_CYC) return (((k - 1) % (SL + 1)) < SL) ? ST_SHIFT : ST_CAPTURE;
    if (k <= PAT_CYC + SL) return ST_UNLOAD;
    if (k == CMP_K) return ST_COMPARE;
    return ST_DONE;
  endfunction

  // bits: test_mode lfsr_seed lfsr_en misr_clr misr_en scan_en bistdone bistpass
  function automatic logic [7:0] exp_out(input int k, input logic pass);
    logic not_first;
    not_first = (((k - 1) / (SL + 1)) != 0);
    case (exp_state(k))
      ST_INIT:    return 8'b1101_0000;
      ST_SHIFT:   return {4'b1010, not_first, 3'b100};
      ST_CAPTURE: return 8'b1010_1000;
      ST_UNLOAD:  return 8'b1010_1100;
      ST_COMPARE: return 8'b1000_0000;
      ST_DONE:    return {6'b100000, 1'b1, pass};
      default:    return 8'h00;
    endcase
  endfunction

  // driver: pulse rst low between edges, checking outputs drop without a clock
  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_out"}, 32'(obs_vec()), 32'h0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    #2 rst = 1'b1;
  endtask

  // driver: one run; caller guarantees the next rising edge enters INIT
  task automatic run(input logic [15:0] sig, input int kind, input int stop_at);
    logic       pass_e;
    logic [7:0] o;
    int         last, n_scan, n_cap, n_misr, n_first;
    pass_e  = (sig == GOLDEN);
    last    = (kind == K_FULL) ? DONE_K + 2 : stop_at;
    n_scan  = 0;
    n_cap   = 0;
    n_misr  = 0;
    n_first = 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      o = obs_vec();
      check("out", 32'(o), 32'(exp_out(k, pass_e)));
      check("state", 32'(state_dbg), 32'(exp_state(k)));
      if (o[2]) n_scan++;
      if (o[5] && !o[2]) n_cap++;
      if (o[3]) begin
        n_misr++;
        if (k >= 1 && k <= SL) n_first++;
      end
      if (kind == K_FULL && k == DONE_K) begin
        check("pat_cnt_done", 32'(pat_cnt_dbg), 32'(NP));
        check("shift_cnt_done", 32'(shift_cnt_dbg), 32'h0);
      end
      misr_sig = (k == CMP_K) ? sig : 16'($urandom);
    end
    if (kind == K_FULL) begin
      check("n_scan", 32'(n_scan), 32'(NP * SL + SL));
      check("n_capture", 32'(n_cap), 32'(NP));
      check("n_misr_en", 32'(n_misr), 32'((NP - 1) * SL + NP + SL));
      check("misr_en_first_load", 32'(n_first), 32'h0);
    end else if (kind == K_ABORT) begin
      bistmode = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(posedge clk);
        #1;
        check("abort_out", 32'(obs_vec()), 32'h0);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
      end
      bistmode = 1'b1;
    end else begin
      async_reset_pulse("mid_reset");
    end
  endtask

  // driver: leave DONE either by dropping bistmode or by a reset pulse
  task automatic end_run(input bit by_reset);
    if (by_reset) begin
      async_reset_pulse("done_reset");
    end else begin
      bistmode = 1'b0;
      @(posedge clk);
      #1;
      check("exit_out", 32'(obs_vec()), 32'h0);
      check("exit_state", 32'(state_dbg), 32'(ST_IDLE));
      bistmode = 1'b1;
    end
  endtask

  function automatic logic [15:0] pick_sig();
    case ($urandom_range(0, 2))
      0:       return GOLDEN;
      1:       return GOLDEN ^ (16'h1 << $urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int kind;
    int stop;
    rst      = 1'b0;
    bistmode = 1'b1;
    misr_sig = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(obs_vec()), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;

    // fault-free run straight out of reset, then exit by dropping bistmode
    run(GOLDEN, K_FULL, 0);
    end_run(1'b0);
    // single-bit signature mismatch, then back-to-back via reset in DONE
    run(16'hBEEE, K_FULL, 0);
    end_run(1'b1);
    run(GOLDEN, K_FULL, 0);
    end_run(1'b1);
    // abort during the second pattern's shift, then a full repeat
    run(GOLDEN, K_ABORT, (SL + 1) + 2);
    run(GOLDEN, K_FULL, 0);
    end_run(1'b0);
    // abort on the CAPTURE->UNLOAD edge
    run(GOLDEN, K_ABORT, PAT_CYC);
    // async reset mid-UNLOAD
    run(GOLDEN, K_RESET, PAT_CYC + 2);
    run(16'h1234, K_FULL, 0);
    end_run(1'b0);

    for (int n = 0; n < 16; n++) begin
      kind = int'($urandom_range(0, 2));
      stop = int'($urandom_range(0, DONE_K + 1));
      run(pick_sig(), kind, stop);
      if (kind == K_FULL) end_run(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
